// File: rtl/aw_snoop_pkg.sv
// Shared types and constants for the AW write-snoop flush gate.
package aw_snoop_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        FLUSH   = 2'd2,
        FORWARD = 2'd3
    } state_e;

    localparam int ERR_WDOG     = 0;
    localparam int ERR_SPUR_ACK = 1;
    localparam int ERR_BITS     = 3;
    localparam int STAT_WIDTH   = 16;

    // Number of streams hit by one AW; NUM_STREAMS never exceeds 16.
    function automatic logic [4:0] count_ones(input logic [STAT_WIDTH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < STAT_WIDTH; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [STAT_WIDTH-1:0] sat_add(input logic [STAT_WIDTH-1:0] a,
                                                      input logic [4:0]            b);
        logic [STAT_WIDTH:0] sum;
        sum = {1'b0, a} + {{(STAT_WIDTH - 4){1'b0}}, b};
        return sum[STAT_WIDTH] ? '1 : sum[STAT_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/aw_snoop_flush_if.sv
// AXI write-address channel subset (valid/ready/addr/id) used on both sides of the gate.
interface aw_snoop_flush_if #(
    parameter int ADDR_BITS = 16,
    parameter int TID_WIDTH = 8
);
    logic                 valid;
    logic                 ready;
    logic [ADDR_BITS-1:0] addr;
    logic [TID_WIDTH-1:0] id;

    modport master (output valid, output addr, output id, input  ready);
    modport slave  (input  valid, input  addr, input  id, output ready);
endinterface

// File: rtl/aw_window_match.sv
// Inclusive address-window compare for one prefetch stream; lo > hi is an empty window.
module aw_window_match #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 active,
    input  logic [ADDR_BITS-1:0] lo,
    input  logic [ADDR_BITS-1:0] hi,
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 hit
);
    assign hit = active && (lo <= addr) && (addr <= hi);
endmodule

// File: rtl/aw_snoop_flush.sv
// Write-snoop gate: holds one AW, flushes every prefetch stream whose window it hits, then forwards it.
// Optional AW_SNOOP_STATS_EN adds saturating flushed-stream and forwarded-AW counters.
module aw_snoop_flush
    import aw_snoop_pkg::*;
#(
    parameter int ADDR_BITS     = 16,
    parameter int TID_WIDTH     = 8,
    parameter int NUM_STREAMS   = 4,
    parameter int WATCHDOG_SIZE = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    aw_snoop_flush_if.slave                  s_aw,
    aw_snoop_flush_if.master                 m_aw,
    input  logic [NUM_STREAMS-1:0]           str_active,
    input  logic [NUM_STREAMS*ADDR_BITS-1:0] str_lo,
    input  logic [NUM_STREAMS*ADDR_BITS-1:0] str_hi,
    output logic [NUM_STREAMS-1:0]           flush_req,
    input  logic [NUM_STREAMS-1:0]           flush_ack,
    input  logic [WATCHDOG_SIZE-1:0]         watchdogCnt,
    output logic [ERR_BITS-1:0]              errorCode
`ifdef AW_SNOOP_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]            stat_flush_cnt,
    output logic [STAT_WIDTH-1:0]            stat_aw_cnt
`endif
);

    state_e                   state, next_state;
    logic                     ready_q;
    logic [ADDR_BITS-1:0]     addr_q;
    logic [TID_WIDTH-1:0]     id_q;
    logic [NUM_STREAMS-1:0]   pending, pending_d;
    logic [WATCHDOG_SIZE-1:0] wdog, wdog_d;
    logic [ERR_BITS-1:0]      err_q, err_d;
    logic                     capture;
    logic [NUM_STREAMS-1:0]   hit;

    for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_match
        aw_window_match #(
            .ADDR_BITS (ADDR_BITS)
        ) u_match (
            .active (str_active[k]),
            .lo     (str_lo[k*ADDR_BITS +: ADDR_BITS]),
            .hi     (str_hi[k*ADDR_BITS +: ADDR_BITS]),
            .addr   (addr_q),
            .hit    (hit[k])
        );
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        pending_d  = pending;
        wdog_d     = wdog;
        err_d      = err_q;
        capture    = 1'b0;

        unique case (state)
            IDLE: begin
                if (s_aw.valid && ready_q) begin
                    capture    = 1'b1;
                    next_state = CHECK;
                end
            end
            CHECK: begin
                pending_d  = hit;
                next_state = (|hit) ? FLUSH : FORWARD;
            end
            FLUSH: begin
                if (|(flush_ack & ~pending)) begin
                    err_d[ERR_SPUR_ACK] = 1'b1;
                end
                pending_d = pending & ~flush_ack;
                wdog_d    = wdog + WATCHDOG_SIZE'(1);
                // A final ack landing on the expiry cycle completes normally, without a watchdog error.
                if (pending_d == '0) begin
                    next_state = FORWARD;
                end else if ((watchdogCnt != '0) && (wdog_d == watchdogCnt)) begin
                    err_d[ERR_WDOG] = 1'b1;
                    pending_d       = '0;
                    next_state      = FORWARD;
                end
            end
            FORWARD: begin
                if (m_aw.ready) begin
                    wdog_d     = '0;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            id_q    <= '0;
            pending <= '0;
            wdog    <= '0;
            err_q   <= '0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE);
            pending <= pending_d;
            wdog    <= wdog_d;
            err_q   <= err_d;
            if (capture) begin
                addr_q <= s_aw.addr;
                id_q   <= s_aw.id;
            end
        end
    end

    assign s_aw.ready = ready_q;
    assign m_aw.valid = (state == FORWARD);
    assign m_aw.addr  = addr_q;
    assign m_aw.id    = id_q;
    assign flush_req  = pending;
    assign errorCode  = err_q;

`ifdef AW_SNOOP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_flush_cnt <= '0;
            stat_aw_cnt    <= '0;
        end else begin
            if (state == CHECK) begin
                stat_flush_cnt <= sat_add(stat_flush_cnt, count_ones(STAT_WIDTH'(hit)));
            end
            if ((state == FORWARD) && m_aw.ready) begin
                stat_aw_cnt <= sat_add(stat_aw_cnt, 5'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_aw_snoop_flush.sv
// Self-checking bench for aw_snoop_flush: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against a transaction-level model.
module tb_aw_snoop_flush;
    import aw_snoop_pkg::*;

    localparam int AB = 16;
    localparam int TW = 8;
    localparam int NS = 4;
    localparam int WS = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] str_active;
    logic [NS*AB-1:0] str_lo, str_hi;
    logic [NS-1:0] flush_req, flush_ack;
    logic [WS-1:0] watchdogCnt;
    logic [2:0]    errorCode;
`ifdef AW_SNOOP_STATS_EN
    logic [15:0]   stat_flush_cnt, stat_aw_cnt;
`endif

    aw_snoop_flush_if #(.ADDR_BITS(AB), .TID_WIDTH(TW)) s_if ();
    aw_snoop_flush_if #(.ADDR_BITS(AB), .TID_WIDTH(TW)) m_if ();

    aw_snoop_flush #(
        .ADDR_BITS(AB), .TID_WIDTH(TW), .NUM_STREAMS(NS), .WATCHDOG_SIZE(WS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_aw       (s_if),
        .m_aw       (m_if),
        .str_active (str_active),
        .str_lo     (str_lo),
        .str_hi     (str_hi),
        .flush_req  (flush_req),
        .flush_ack  (flush_ack),
        .watchdogCnt(watchdogCnt),
        .errorCode  (errorCode)
`ifdef AW_SNOOP_STATS_EN
        ,
        .stat_flush_cnt(stat_flush_cnt),
        .stat_aw_cnt   (stat_aw_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // holding: an AW has been accepted and not yet forwarded; snooped: its windows were checked.
    bit          model_live = 1'b0;
    bit          holding, snooped, just_reset, ready_now;
    logic [15:0] mdl_addr;
    logic [7:0]  mdl_id;
    logic [3:0]  mdl_pend;
    logic [2:0]  mdl_err;
    int          flush_age, mdl_flushed, mdl_fwd;

    function automatic logic [3:0] window_hits(input logic [15:0] a);
        logic [3:0] h;
        int lo, hi;
        h = '0;
        for (int k = 0; k < NS; k++) begin
            lo = int'(str_lo[k*AB +: AB]);
            hi = int'(str_hi[k*AB +: AB]);
            h[k] = str_active[k] && (lo <= int'(a)) && (int'(a) <= hi);
        end
        return h;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_live = 1'b1;
            holding = 1'b0; snooped = 1'b0; just_reset = 1'b1;
            mdl_addr = '0; mdl_id = '0; mdl_pend = '0; mdl_err = '0;
            flush_age = 0; mdl_flushed = 0; mdl_fwd = 0;
        end else if (model_live) begin
            ready_now  = !holding && !just_reset;
            just_reset = 1'b0;
            if (!holding) begin
                if (s_if.valid && ready_now) begin
                    holding = 1'b1; snooped = 1'b0;
                    mdl_addr = s_if.addr; mdl_id = s_if.id;
                end
            end else if (!snooped) begin
                mdl_pend  = window_hits(mdl_addr);
                snooped   = 1'b1;
                flush_age = 0;
                mdl_flushed = mdl_flushed + $countones(mdl_pend);
                if (mdl_flushed > 65535) mdl_flushed = 65535;
            end else if (mdl_pend != 0) begin
                if ((flush_ack & ~mdl_pend) != 0) mdl_err[1] = 1'b1;
                mdl_pend  = mdl_pend & ~flush_ack;
                flush_age = flush_age + 1;
                if (mdl_pend != 0 && watchdogCnt != 0 && flush_age == int'(watchdogCnt)) begin
                    mdl_err[0] = 1'b1;
                    mdl_pend   = '0;
                end
            end else if (m_if.ready) begin
                holding = 1'b0;
                if (mdl_fwd < 65535) mdl_fwd = mdl_fwd + 1;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("cmp_s_ready", 32'(s_if.ready), 32'(!holding && !just_reset));
            check("cmp_m_valid", 32'(m_if.valid), 32'(holding && snooped && mdl_pend == 0));
            check("cmp_m_addr",  32'(m_if.addr),  32'(mdl_addr));
            check("cmp_m_id",    32'(m_if.id),    32'(mdl_id));
            check("cmp_flush_req", 32'(flush_req), 32'(mdl_pend));
            check("cmp_error",   32'(errorCode),  32'(mdl_err));
`ifdef AW_SNOOP_STATS_EN
            check("cmp_stat_flush", 32'(stat_flush_cnt), 32'(mdl_flushed));
            check("cmp_stat_aw",    32'(stat_aw_cnt),    32'(mdl_fwd));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_win(input int k, input logic [15:0] lo, input logic [15:0] hi);
        str_lo[k*AB +: AB] = lo;
        str_hi[k*AB +: AB] = hi;
    endtask

    task automatic default_windows();
        str_active = 4'b1111;
        set_win(0, 16'h1000, 16'h10FF);
        set_win(1, 16'h2000, 16'h20FF);
        set_win(2, 16'h3000, 16'h30FF);
        set_win(3, 16'h4000, 16'h40FF);
    endtask

    // Presents an AW and returns just after the accepting edge (DUT then in its check cycle).
    task automatic send_aw(input logic [15:0] a, input logic [7:0] i);
        bit hs;
        hs = 1'b0;
        s_if.valid = 1'b1; s_if.addr = a; s_if.id = i;
        for (int n = 0; n < 40 && !hs; n++) begin
            @(negedge clk);
            hs = s_if.ready;
            tick();
        end
        s_if.valid = 1'b0;
        check("aw_accept", 32'(hs), 32'd1);
    endtask

    task automatic randomize_windows();
        logic [15:0] lo, hi;
        for (int k = 0; k < NS; k++) begin
            lo = 16'($urandom_range(0, 16'h0FFF));
            hi = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'h0FFF))
                                             : lo + 16'($urandom_range(0, 16'h0300));
            set_win(k, lo, hi);
        end
        str_active = 4'($urandom_range(0, 15));
    endtask

    int wd_cycles;
    bit wd_done;

    initial begin
        rst = 1'b1;
        s_if.valid = 1'b0; s_if.addr = '0; s_if.id = '0;
        m_if.ready = 1'b1;
        flush_ack = '0; watchdogCnt = '0;
        str_active = '0; str_lo = '0; str_hi = '0;
        tick(); tick();

        // Reset state
        @(negedge clk);
        check("rst_s_ready", 32'(s_if.ready), 32'd0);
        check("rst_m_valid", 32'(m_if.valid), 32'd0);
        check("rst_flush_req", 32'(flush_req), 32'd0);
        check("rst_error", 32'(errorCode), 32'd0);
        check("rst_m_addr", 32'(m_if.addr), 32'd0);
        tick();
        rst = 1'b0;
        default_windows();
        tick();
        @(negedge clk);
        check("rel_s_ready", 32'(s_if.ready), 32'd1);
        tick();

        // No hit: forwarded two cycles after the upstream handshake
        send_aw(16'h5000, 8'd5);
        @(negedge clk);
        check("nohit_check_valid", 32'(m_if.valid), 32'd0);
        check("nohit_flush", 32'(flush_req), 32'd0);
        tick();
        @(negedge clk);
        check("nohit_fwd_valid", 32'(m_if.valid), 32'd1);
        check("nohit_fwd_addr", 32'(m_if.addr), 32'h5000);
        check("nohit_fwd_id", 32'(m_if.id), 32'd5);
        tick();

        // Single hit on stream 1, ack after 3 flush cycles
        send_aw(16'h2010, 8'd7);
        tick();
        @(negedge clk);
        check("single_req", 32'(flush_req), 32'b0010);
        tick(); tick();
        flush_ack = 4'b0010;
        tick();
        flush_ack = '0;
        @(negedge clk);
        check("single_req_drop", 32'(flush_req), 32'd0);
        check("single_fwd_valid", 32'(m_if.valid), 32'd1);
        check("single_fwd_addr", 32'(m_if.addr), 32'h2010);
        tick();

        // Multi hit on streams 0 and 2, acked separately
        set_win(0, 16'h0EEF, 16'h0F00);
        set_win(2, 16'h0EEF, 16'h0F00);
        send_aw(16'h0EF2, 8'd9);
        tick();
        @(negedge clk);
        check("multi_req", 32'(flush_req), 32'b0101);
        flush_ack = 4'b0100;
        tick();
        flush_ack = '0;
        @(negedge clk);
        check("multi_req_after_first", 32'(flush_req), 32'b0001);
        check("multi_hold_valid", 32'(m_if.valid), 32'd0);
        flush_ack = 4'b0001;
        tick();
        flush_ack = '0;
        @(negedge clk);
        check("multi_req_done", 32'(flush_req), 32'd0);
        check("multi_fwd_valid", 32'(m_if.valid), 32'd1);
        check("multi_error", 32'(errorCode), 32'd0);
        tick();
        default_windows();

        // Watchdog expiry after 10 unacknowledged flush cycles
        watchdogCnt = 10'd10;
        send_aw(16'h1050, 8'd3);
        tick();
        wd_cycles = 0;
        wd_done   = 1'b0;
        for (int n = 0; n < 30 && !wd_done; n++) begin
            @(negedge clk);
            if (flush_req != '0) begin
                wd_cycles++;
                tick();
            end else begin
                wd_done = 1'b1;
            end
        end
        check("wdog_flush_cycles", 32'(wd_cycles), 32'd10);
        check("wdog_error", 32'(errorCode), 32'b001);
        check("wdog_fwd_valid", 32'(m_if.valid), 32'd1);
        check("wdog_fwd_addr", 32'(m_if.addr), 32'h1050);
        tick();
        watchdogCnt = '0;

        // Exact upper bound hits; unsolicited ack flags an error
        send_aw(16'h10FF, 8'd4);
        tick();
        @(negedge clk);
        check("bound_hi_hit", 32'(flush_req), 32'b0001);
        flush_ack = 4'b1000;
        tick();
        flush_ack = '0;
        @(negedge clk);
        check("spur_error", 32'(errorCode), 32'b011);
        check("spur_req_kept", 32'(flush_req), 32'b0001);
        flush_ack = 4'b0001;
        tick();
        flush_ack = '0;
        @(negedge clk);
        check("spur_fwd_valid", 32'(m_if.valid), 32'd1);
        tick();

        // Inverted window never hits
        set_win(3, 16'h0020, 16'h0010);
        send_aw(16'h0018, 8'd6);
        tick();
        @(negedge clk);
        check("empty_win_req", 32'(flush_req), 32'd0);
        check("empty_win_fwd", 32'(m_if.valid), 32'd1);
        tick();
        default_windows();

        // Downstream backpressure: address/id held, upstream blocked
        m_if.ready = 1'b0;
        send_aw(16'h5500, 8'h0A);
        tick();
        s_if.valid = 1'b1; s_if.addr = 16'h1234; s_if.id = 8'h77;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check("bp_valid", 32'(m_if.valid), 32'd1);
            check("bp_addr", 32'(m_if.addr), 32'h5500);
            check("bp_id", 32'(m_if.id), 32'h0A);
            check("bp_s_ready", 32'(s_if.ready), 32'd0);
            tick();
        end
        s_if.valid = 1'b0;
        m_if.ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_done_valid", 32'(m_if.valid), 32'd0);
        check("bp_done_s_ready", 32'(s_if.ready), 32'd1);
        tick();

        // Reset while flushing drops the AW
        send_aw(16'h2010, 8'h21);
        tick();
        @(negedge clk);
        check("rstf_req", 32'(flush_req), 32'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstf_req_clr", 32'(flush_req), 32'd0);
        check("rstf_valid", 32'(m_if.valid), 32'd0);
        check("rstf_s_ready", 32'(s_if.ready), 32'd0);
        check("rstf_error", 32'(errorCode), 32'd0);
        check("rstf_addr", 32'(m_if.addr), 32'd0);
        check("rstf_id", 32'(m_if.id), 32'd0);
        tick();
        @(negedge clk);
        check("rstf_rel_ready", 32'(s_if.ready), 32'd1);
        check("rstf_dropped", 32'(m_if.valid), 32'd0);
        tick();

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 4000; c++) begin
            int k;
            rst = ($urandom_range(0, 299) == 0);
            if (!holding && $urandom_range(0, 7) == 0)
                watchdogCnt = ($urandom_range(0, 1) == 0) ? '0 : WS'($urandom_range(1, 6));
            if ($urandom_range(0, 15) == 0) randomize_windows();
            s_if.valid = 1'($urandom_range(0, 1));
            s_if.id    = 8'($urandom_range(0, 255));
            k = int'($urandom_range(0, NS - 1));
            case ($urandom_range(0, 3))
                0: s_if.addr = str_lo[k*AB +: AB];
                1: s_if.addr = str_hi[k*AB +: AB];
                default: s_if.addr = 16'($urandom_range(0, 16'h12FF));
            endcase
            m_if.ready = ($urandom_range(0, 2) != 0);
            flush_ack = '0;
            for (int b = 0; b < NS; b++) begin
                if (mdl_pend[b] && $urandom_range(0, 3) == 0) flush_ack[b] = 1'b1;
                else if (!mdl_pend[b] && mdl_pend != 0 && $urandom_range(0, 63) == 0)
                    flush_ack[b] = 1'b1;
            end
            tick();
        end
        rst = 1'b0;
        s_if.valid = 1'b0;
        flush_ack = '0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
